// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter: default bus widths,
// FSM state encoding and transfer direction values.
package mem_bus_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic DIR_READ  = 1'b1;
  localparam logic DIR_WRITE = 1'b0;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from
// the slot after the previous winner, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    // NOTE: every variable written here gets a default first, so no path
    // can leave it unassigned and infer a latch.
    cand   = '0;
    winner = '0;
    // Scan farthest-first so the nearest set request is the last one written.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) winner = cand;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the shared memory bus: grants one requester, runs a
// single bus transaction with a VALID timeout, then releases the bus.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_rd_wr_bar,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic [DATA_WIDTH-1:0]         mem_data_out,
  output logic                          mem_data_oe,
  input  logic [DATA_WIDTH-1:0]         mem_data_in,
  output logic                          mem_rd_wr_bar,
  output logic                          mem_cs,
  input  logic                          mem_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rw_q, rw_d;
  logic                  cs_q, cs_d;
  logic                  oe_q, oe_d;

  logic [IDX_W-1:0]      winner;
  logic                  any_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    cs_d    = cs_q;
    oe_d    = oe_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d        = ACCESS;
          ptr_d          = winner;
          cnt_d          = '0;
          gnt_d          = '0;
          gnt_d[winner]  = 1'b1;
          cs_d           = 1'b1;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == winner) begin
              addr_d  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_d = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
              rw_d    = req_rd_wr_bar[i];
            end
          end
          oe_d = (rw_d == DIR_WRITE);
        end
      end

      ACCESS: begin
        // VALID is checked before the timeout so a late slave still wins.
        if (mem_valid) begin
          if (rw_q == DIR_READ) rdata_d = mem_data_in;
          done_d  = gnt_q;
          cs_d    = 1'b0;
          oe_d    = 1'b0;
          state_d = RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done_d  = gnt_q;
          err_d   = 1'b1;
          cs_d    = 1'b0;
          oe_d    = 1'b0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RELEASE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        gnt_d   = '0;
        cs_d    = 1'b0;
        oe_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= DIR_READ;
      cs_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      cs_q    <= cs_d;
      oe_q    <= oe_d;
    end
  end

  assign gnt           = gnt_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign mem_address   = addr_q;
  assign mem_data_out  = wdata_q;
  assign mem_data_oe   = oe_q;
  assign mem_rd_wr_bar = rw_q;
  assign mem_cs        = cs_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// random traffic, checked against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int NR = 2;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_rd_wr_bar;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     done;
  logic              err;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     mem_address;
  logic [DW-1:0]     mem_data_out;
  logic              mem_data_oe;
  logic [DW-1:0]     mem_data_in;
  logic              mem_rd_wr_bar;
  logic              mem_cs;
  logic              mem_valid;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_rd_wr_bar (req_rd_wr_bar),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .gnt           (gnt),
    .done          (done),
    .err           (err),
    .rdata         (rdata),
    .mem_address   (mem_address),
    .mem_data_out  (mem_data_out),
    .mem_data_oe   (mem_data_oe),
    .mem_data_in   (mem_data_in),
    .mem_rd_wr_bar (mem_rd_wr_bar),
    .mem_cs        (mem_cs),
    .mem_valid     (mem_valid)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending transaction per requester, last winner, and
  // the read data the requesters should currently see.
  logic        pend    [NR];
  logic        p_rw    [NR];
  logic [15:0] p_addr  [NR];
  logic [7:0]  p_wdata [NR];
  logic [7:0]  p_rdata [NR];
  int          p_lat   [NR];
  int          last;
  logic [7:0]  exp_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick();
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (last + k) % NR;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req[i]                 = pend[i];
      req_rd_wr_bar[i]       = p_rw[i];
      req_addr[i*AW +: AW]   = p_addr[i];
      req_wdata[i*DW +: DW]  = p_wdata[i];
    end
  endtask

  task automatic arm(input int i, input logic rw, input logic [15:0] a,
                     input logic [7:0] wd, input logic [7:0] rd, input int lat);
    pend[i]    = 1'b1;
    p_rw[i]    = rw;
    p_addr[i]  = a;
    p_wdata[i] = wd;
    p_rdata[i] = rd;
    p_lat[i]   = lat;
  endtask

  task automatic arm_rand(input int i, input bit allow_timeout);
    int lat;
    lat = $urandom_range(0, 3);
    if (allow_timeout && $urandom_range(0, 5) == 0) lat = $urandom_range(TO - 2, TO + 2);
    arm(i, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom), lat);
  endtask

  // Called at the start of an IDLE cycle with at least one request pending;
  // returns at the start of the IDLE cycle that follows RELEASE.
  task automatic do_txn();
    int w;
    bit to;
    w  = pick();
    to = (p_lat[w] >= TO);
    drive_reqs();
    @(negedge clk);
    check("idle_gnt", gnt, 0);
    check("idle_cs", mem_cs, 0);
    check("idle_done", done, 0);
    @(posedge clk); #1;
    for (int k = 0; k < TO; k++) begin
      mem_valid   = (k == p_lat[w]);
      mem_data_in = (k == p_lat[w]) ? p_rdata[w] : 8'($urandom);
      if ($urandom_range(0, 3) == 0) req[w] = 1'b0;
      @(negedge clk);
      check("acc_gnt", gnt, onehot(w));
      check("acc_cs", mem_cs, 1);
      check("acc_addr", mem_address, p_addr[w]);
      check("acc_dir", mem_rd_wr_bar, p_rw[w]);
      check("acc_oe", mem_data_oe, !p_rw[w]);
      if (!p_rw[w]) check("acc_wdata", mem_data_out, p_wdata[w]);
      check("acc_done", done, 0);
      check("acc_err", err, 0);
      @(posedge clk); #1;
      if (k == p_lat[w]) break;
    end
    if (!to && p_rw[w]) exp_rdata = p_rdata[w];
    pend[w]     = 1'b0;
    last        = w;
    mem_valid   = 1'($urandom);
    mem_data_in = 8'($urandom);
    drive_reqs();
    @(negedge clk);
    check("rel_done", done, onehot(w));
    check("rel_err", err, to);
    check("rel_rdata", rdata, exp_rdata);
    check("rel_cs", mem_cs, 0);
    check("rel_oe", mem_data_oe, 0);
    check("rel_gnt", gnt, onehot(w));
    @(posedge clk); #1;
    mem_valid = 1'($urandom);
  endtask

  initial begin
    reset       = 1'b0;
    mem_valid   = 1'b0;
    mem_data_in = '0;
    for (int i = 0; i < NR; i++) arm_rand(i, 0);
    drive_reqs();
    last      = NR - 1;
    exp_rdata = '0;

    // Reset held for 3 cycles with both requests raised.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_cs", mem_cs, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_rdata", rdata, 0);
      check("rst_oe", mem_data_oe, 0);
      check("rst_dir", mem_rd_wr_bar, 1);
      check("rst_addr", mem_address, 0);
      check("rst_wdata", mem_data_out, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    drive_reqs();

    // Single read, VALID in the second ACCESS cycle.
    arm(0, 1'b1, 16'h1234, 8'h00, 8'hA5, 1);
    do_txn();

    // Write with a zero-wait slave.
    arm(1, 1'b0, 16'hBEEF, 8'h3C, 8'h00, 0);
    do_txn();

    // Both requests held: grants must alternate 0,1,0,1.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NR; i++) if (!pend[i]) arm_rand(i, 0);
      do_txn();
    end

    // Timeout on a read: rdata must keep its previous value.
    arm(0, 1'b1, 16'h0F0F, 8'h00, 8'h77, 100);
    do_txn();

    // VALID arriving on the last counted cycle beats the timeout.
    pend[0] = 1'b0;
    arm(1, 1'b1, 16'h4242, 8'h00, 8'h5A, TO - 1);
    do_txn();

    // Reset asserted in the 3rd ACCESS cycle aborts without done/err.
    arm(0, 1'b1, 16'hCAFE, 8'h00, 8'h11, 100);
    drive_reqs();
    @(negedge clk);
    check("mid_idle_gnt", gnt, 0);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("mid_acc_cs", mem_cs, 1);
      check("mid_acc_gnt", gnt, onehot(0));
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    check("mid_acc3_cs", mem_cs, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_cs", mem_cs, 0);
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_rdata", rdata, 0);
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    last      = NR - 1;
    exp_rdata = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    arm(1, 1'b0, 16'h5555, 8'hC3, 8'h00, 2);
    do_txn();
    arm(0, 1'b1, 16'hAAAA, 8'h00, 8'h96, 0);
    do_txn();

    // Random traffic.
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < NR; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) arm_rand(i, 1);
      drive_reqs();
      if (pick() >= 0) begin
        do_txn();
      end else begin
        @(negedge clk);
        check("idle_only_gnt", gnt, 0);
        check("idle_only_cs", mem_cs, 0);
        check("idle_only_done", done, 0);
        @(posedge clk); #1;
        mem_valid = 1'($urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
